// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: datapath width, divider
// iteration count and the common sequencer state encoding.
package muldiv_pkg;

    localparam int unsigned MulDivWidth    = 32;
    localparam int unsigned DivIterations  = 32;
    localparam int unsigned IterCountWidth = $clog2(DivIterations);

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StFix,
        StDone,
        StZero
    } mdState_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   divAbs,
    output logic [WIDTH:0]   remNext,
    output logic [WIDTH-1:0] qNext
);

    localparam int unsigned RemW = WIDTH + 1;

    // One extra bit so the shifted remainder can never overflow the compare.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divExt;
    logic             fits;

    always_comb begin
        shifted = {rem, q[WIDTH-1]};
        divExt  = {1'b0, divAbs};
        fits    = (shifted >= divExt);
        remNext = fits ? RemW'(shifted - divExt) : RemW'(shifted);
        qNext   = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: one restoring step per cycle on operand
// magnitudes, signs reapplied in a final fix-up cycle. LO=quotient, HI=remainder.
module seq_divider
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MulDivWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_zero,
    output logic             busy
);

    localparam logic [IterCountWidth-1:0] LastCount = IterCountWidth'(DivIterations - 1);
    localparam logic [IterCountWidth-1:0] CountOne  = IterCountWidth'(1);

    mdState_e                  state;
    logic [IterCountWidth-1:0] count;
    logic [WIDTH:0]            remReg;
    logic [WIDTH-1:0]          quotReg;
    logic [WIDTH:0]            divAbs;
    logic                      qNeg;
    logic                      rNeg;

    logic [WIDTH-1:0]          dividendMag;
    logic [WIDTH-1:0]          divisorMag;
    logic [WIDTH:0]            remNext;
    logic [WIDTH-1:0]          quotNext;

    // Unsigned negation of 0x80000000 yields 0x80000000, i.e. the correct magnitude.
    always_comb begin
        dividendMag = dividend[WIDTH-1] ? -dividend : dividend;
        divisorMag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) uStep (
        .rem     (remReg),
        .q       (quotReg),
        .divAbs  (divAbs),
        .remNext (remNext),
        .qNext   (quotNext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            count    <= '0;
            remReg   <= '0;
            quotReg  <= '0;
            divAbs   <= '0;
            qNeg     <= 1'b0;
            rNeg     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state    <= StZero;
                            div_zero <= 1'b1;
                        end else begin
                            state   <= StCalc;
                            count   <= '0;
                            remReg  <= '0;
                            quotReg <= dividendMag;
                            divAbs  <= {1'b0, divisorMag};
                            qNeg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            rNeg    <= dividend[WIDTH-1];
                        end
                    end
                end
                StCalc: begin
                    remReg  <= remNext;
                    quotReg <= quotNext;
                    count   <= count + CountOne;
                    if (count == LastCount) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    // Quotient wraps mod 2^WIDTH; 0x80000000 / -1 lands back on 0x80000000.
                    lo    <= qNeg ? -quotReg : quotReg;
                    hi    <= rNeg ? -remReg[WIDTH-1:0] : remReg[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                StZero: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider: results, signs, latency,
// divide-by-zero, ignored starts and mid-operation reset.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        divZero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_divider #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .hi       (hi),
        .lo       (lo),
        .done     (done),
        .div_zero (divZero),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expLo;
        logic [31:0] expHi;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pulses start for edge 0; on return the bench sits #1 into cycle 1.
    task automatic pulseStart(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full operation: done must appear in cycle 34 with the given results, busy low in 35.
    task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eLo, input logic [31:0] eHi);
        int lat;
        logic zeroSeen;
        lat      = 0;
        zeroSeen = 1'b0;
        pulseStart(a, b);
        for (int c = 1; c <= 40; c++) begin
            if (divZero) zeroSeen = 1'b1;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({name, " latency"}, lat, 34);
        check({name, " lo"}, lo, eLo);
        check({name, " hi"}, hi, eHi);
        check({name, " div_zero"}, {31'b0, zeroSeen | divZero}, 32'd0);
        @(posedge clk);
        #1;
        check({name, " busy after"}, {31'b0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] mag(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] mq;
        logic [31:0] mr;
        logic [31:0] eLo;
        logic [31:0] eHi;
        int lat;
        logic sawDone;

        vecs[0]  = '{32'd100,      32'd7,          32'd14,         32'd2};
        vecs[1]  = '{-32'sd100,    32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
        vecs[2]  = '{32'd100,      -32'sd7,        32'hFFFFFFF2,   32'd2};
        vecs[3]  = '{-32'sd100,    -32'sd7,        32'd14,         32'hFFFFFFFE};
        vecs[4]  = '{32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[5]  = '{32'd5,        32'h80000000,   32'd0,          32'd5};
        vecs[6]  = '{32'd0,        32'd5,          32'd0,          32'd0};
        vecs[7]  = '{32'd3,        32'd10,         32'd0,          32'd3};
        vecs[8]  = '{-32'sd3,      32'd10,         32'd0,          32'hFFFFFFFD};
        vecs[9]  = '{32'h80000000, 32'd1,          32'h80000000,   32'd0};
        vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF,   32'd1,          32'd0};
        vecs[11] = '{32'h7FFFFFFF, 32'd2,          32'h3FFFFFFF,   32'd1};
        vecs[12] = '{32'hFFFFFFF9, 32'h80000000,   32'd0,          32'hFFFFFFF9};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset flags", {29'b0, done, divZero, busy}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expLo, vecs[i].expHi);
        end

        // Divide by zero: one-cycle flag, results untouched, next start accepted.
        runOp("pre-zero", 32'd100, 32'd7, 32'd14, 32'd2);
        pulseStart(32'd42, 32'd0);
        check("zero cycle1 div_zero", {31'b0, divZero}, 32'd1);
        check("zero cycle1 done", {31'b0, done}, 32'd0);
        check("zero cycle1 busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("zero cycle2 div_zero", {31'b0, divZero}, 32'd0);
        check("zero cycle2 busy", {31'b0, busy}, 32'd0);
        check("zero keeps lo", lo, 32'd14);
        check("zero keeps hi", hi, 32'd2);
        sawDone = 1'b0;
        repeat (36) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        check("zero no done", {31'b0, sawDone}, 32'd0);
        runOp("post-zero", 32'd50, 32'd6, 32'd8, 32'd2);

        // Start while busy at cycle 10 is ignored; start in DONE cycle also ignored.
        pulseStart(32'd100, 32'd7);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("busy-start latency", lat, 34);
        check("busy-start lo", lo, 32'd14);
        check("busy-start hi", hi, 32'd2);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done-cycle start ignored", {31'b0, busy}, 32'd0);
        runOp("after done-cycle start", 32'd9, 32'd3, 32'd3, 32'd0);

        // Reset mid-operation clears outputs with no done pulse; reset beats start.
        pulseStart(32'd1000, 32'd3);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort hi", hi, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        check("abort stays idle", {31'b0, sawDone}, 32'd0);

        // Randomised pairs against a magnitude/sign reference.
        for (int i = 0; i < 10; i++) begin
            a = $urandom();
            if (i % 2 == 0) begin
                b = $urandom_range(1, 1000);
                if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            end else begin
                b = $urandom();
                if (b == 0) b = 32'd13;
            end
            mq  = mag(a) / mag(b);
            mr  = mag(a) % mag(b);
            eLo = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
            eHi = a[31] ? (32'd0 - mr) : mr;
            runOp($sformatf("rand%0d", i), a, b, eLo, eHi);
            check($sformatf("rand%0d identity", i), lo * b + hi, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
